chunked_one_counter: RTL and testbench

Parametrised, sequential successor to the combinational ones counter. It accepts a WIDTH-bit word on a valid/ready handshake and counts its set bits, or its clear bits in zeros mode, CHUNK bits per clock. It then presents the count plus a threshold-compare flag on a second valid/ready handshake. It sits between a streaming data source (switch/bus sampler) and a status consumer (LED driver, interrupt logic).

---
 rtl/chunked_one_counter_pkg.sv | 28 ++
 rtl/chunked_one_counter_if.sv | 29 ++
 rtl/chunked_one_counter_chunk_popcount.sv | 19 +
 rtl/chunked_one_counter.sv | 109 ++++++++++
 tb/tb_chunked_one_counter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/chunked_one_counter_pkg.sv
// rtl/chunked_one_counter_pkg.sv - shared types, mode constants and width helpers
package chunked_one_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ONES  = 1'b0;
    localparam logic MODE_ZEROS = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int count_w(input int width);
        return clog2(width + 1);
    endfunction

    function automatic int nbeats(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunked_one_counter_if.sv
// rtl/chunked_one_counter_if.sv - word-in / count-out handshake bundle
interface chunked_one_counter_if #(
    parameter int WIDTH = 32
);
    import chunked_one_counter_pkg::*;

    localparam int COUNT_W = count_w(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               in_zeros;
    logic [COUNT_W-1:0] in_threshold;
    logic               out_valid;
    logic               out_ready;
    logic [COUNT_W-1:0] out_count;
    logic               out_ge;

    modport master (
        output in_valid, in_data, in_zeros, in_threshold, out_ready,
        input  in_ready, out_valid, out_count, out_ge
    );

    modport slave (
        input  in_valid, in_data, in_zeros, in_threshold, out_ready,
        output in_ready, out_valid, out_count, out_ge
    );

endinterface

// File: rtl/chunked_one_counter_chunk_popcount.sv
// rtl/chunked_one_counter_chunk_popcount.sv - combinational popcount of one CHUNK-bit slice
module chunk_popcount
    import chunked_one_counter_pkg::*;
#(
    parameter  int CHUNK = 8,
    localparam int PC_W  = clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] data,
    output logic [PC_W-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + PC_W'(data[i]);
        end
    end

endmodule

// File: rtl/chunked_one_counter.sv
// rtl/chunked_one_counter.sv - counts set (or clear) bits of a word CHUNK bits per clock
module chunked_one_counter
    import chunked_one_counter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic clock,
    input  logic reset,
    chunked_one_counter_if.slave bus
);

    localparam int COUNT_W = count_w(WIDTH);
    localparam int NBEATS  = nbeats(WIDTH, CHUNK);
    localparam int PC_W    = clog2(CHUNK + 1);
    localparam int BEAT_W  = (NBEATS > 1) ? clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("chunked_one_counter: WIDTH must be a positive multiple of CHUNK");
    end
    if ($bits(bus.in_data) != WIDTH) begin : g_bad_if
        $error("chunked_one_counter: interface WIDTH does not match WIDTH");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [COUNT_W-1:0] acc_q, acc_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ge_q, ge_d;
    logic [COUNT_W-1:0] thr_q, thr_d;

    logic [PC_W-1:0]    chunk_cnt;
    logic [COUNT_W-1:0] sum;
    logic               in_ready;
    logic               accept;

    chunk_popcount #(.CHUNK(CHUNK)) u_chunk_popcount (
        .data  (shift_q[CHUNK-1:0]),
        .count (chunk_cnt)
    );

    assign sum      = acc_q + COUNT_W'(chunk_cnt);
    assign in_ready = !reset && (state_q == IDLE || (state_q == DONE && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;

    // Mode is folded into the shift register at accept, so counting is always of ones.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        count_d = count_q;
        ge_d    = ge_q;
        thr_d   = thr_q;
        case (state_q)
            IDLE: ;
            BUSY: begin
                acc_d   = sum;
                shift_d = shift_q >> CHUNK;
                beat_d  = beat_q + BEAT_W'(1);
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    count_d = sum;
                    ge_d    = (sum >= thr_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            shift_d = (bus.in_zeros == MODE_ZEROS) ? ~bus.in_data : bus.in_data;
            thr_d   = bus.in_threshold;
            acc_d   = '0;
            beat_d  = '0;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            beat_q  <= '0;
            count_q <= '0;
            ge_q    <= 1'b0;
            thr_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            count_q <= count_d;
            ge_q    <= ge_d;
            thr_q   <= thr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_count = count_q;
    assign bus.out_ge    = ge_q;

endmodule

// File: tb/tb_chunked_one_counter.sv
// tb/tb_chunked_one_counter.sv - two lanes (CHUNK 8 and 32) checked against a transaction-level model
module tb_chunked_one_counter;
    import chunked_one_counter_pkg::*;

    localparam int WIDTH = 32;
    localparam int CW    = 6;
    localparam int NL    = 2;

    function automatic int chunk_of(input int l);
        return (l == 0) ? 8 : 32;
    endfunction

    logic clk;
    logic          rst_s       [NL];
    logic          in_valid_s  [NL];
    logic [31:0]   in_data_s   [NL];
    logic          in_zeros_s  [NL];
    logic [CW-1:0] thr_s       [NL];
    logic          out_ready_s [NL];
    logic [NL-1:0] in_ready_s;
    logic [NL-1:0] out_valid_s;
    logic [NL-1:0] out_ge_s;
    logic [CW-1:0] out_count_s [NL];

    logic lit_on_s  [NL];
    int   lit_cnt_s [NL];
    logic lit_ge_s  [NL];
    int   lit_lat_s [NL];

    bit chk_on  = 0;
    bit rand_bp = 0;
    int tmo_cnt = 0;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int CH = (g == 0) ? 8 : 32;
        chunked_one_counter_if #(.WIDTH(WIDTH)) bus ();
        assign bus.in_valid     = in_valid_s[g];
        assign bus.in_data      = in_data_s[g];
        assign bus.in_zeros     = in_zeros_s[g];
        assign bus.in_threshold = thr_s[g];
        assign bus.out_ready    = out_ready_s[g];
        assign in_ready_s[g]    = bus.in_ready;
        assign out_valid_s[g]   = bus.out_valid;
        assign out_count_s[g]   = bus.out_count;
        assign out_ge_s[g]      = bus.out_ge;
        chunked_one_counter #(.WIDTH(WIDTH), .CHUNK(CH)) dut (
            .clock (clk),
            .reset (rst_s[g]),
            .bus   (bus)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transaction model: a word in flight becomes a result NBEATS edges after accept.
    int m_wait  [NL] = '{0, 0};
    bit m_res   [NL] = '{0, 0};
    int m_cnt   [NL] = '{0, 0};
    bit m_ge    [NL] = '{0, 0};
    int f_cnt   [NL] = '{0, 0};
    bit f_ge    [NL] = '{0, 0};
    bit m_rstd  [NL] = '{0, 0};

    function automatic bit m_ready(input int l);
        return !rst_s[l] && m_wait[l] == 0 && (!m_res[l] || out_ready_s[l]);
    endfunction

    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            bit take;
            take = m_ready(l) && in_valid_s[l];
            m_rstd[l] = rst_s[l];
            if (rst_s[l]) begin
                m_wait[l] = 0;
                m_res[l]  = 0;
            end else begin
                if (m_res[l] && out_ready_s[l]) m_res[l] = 0;
                if (m_wait[l] > 0) begin
                    m_wait[l]--;
                    if (m_wait[l] == 0) begin
                        m_res[l] = 1;
                        m_cnt[l] = f_cnt[l];
                        m_ge[l]  = f_ge[l];
                    end
                end
                if (take) begin
                    f_cnt[l]  = in_zeros_s[l] ? $countones(~in_data_s[l]) : $countones(in_data_s[l]);
                    f_ge[l]   = f_cnt[l] >= int'(thr_s[l]);
                    m_wait[l] = WIDTH / chunk_of(l);
                end
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int tmo_seen = 0;
    int lit_age [NL] = '{-1, -1};
    int lit_c   [NL] = '{0, 0};
    bit lit_g   [NL] = '{0, 0};
    int lit_l   [NL] = '{0, 0};

    task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane%0d t=%0t: got %0d want %0d", nm, l, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (tmo_cnt != tmo_seen) begin
                chk("accept_timeout", 0, tmo_cnt, tmo_seen);
                tmo_seen = tmo_cnt;
            end
            for (int l = 0; l < NL; l++) begin
                chk("in_ready", l, 32'(in_ready_s[l]), 32'(m_ready(l)));
                chk("out_valid", l, 32'(out_valid_s[l]), 32'(m_res[l]));
                if (m_res[l]) begin
                    chk("out_count", l, 32'(out_count_s[l]), m_cnt[l]);
                    chk("out_ge", l, 32'(out_ge_s[l]), 32'(m_ge[l]));
                end
                if (m_rstd[l]) begin
                    chk("reset_count", l, 32'(out_count_s[l]), 0);
                    chk("reset_ge", l, 32'(out_ge_s[l]), 0);
                    lit_age[l] = -1;
                end
                if (lit_age[l] >= 0) begin
                    lit_age[l]++;
                    if (lit_age[l] == lit_l[l]) begin
                        chk("lit_early", l, 32'(out_valid_s[l]), 0);
                    end else if (lit_age[l] == lit_l[l] + 1) begin
                        chk("lit_valid", l, 32'(out_valid_s[l]), 1);
                        chk("lit_count", l, 32'(out_count_s[l]), lit_c[l]);
                        chk("lit_ge", l, 32'(out_ge_s[l]), 32'(lit_g[l]));
                        lit_age[l] = -1;
                    end
                end
                if (lit_on_s[l] && in_valid_s[l] && in_ready_s[l]) begin
                    lit_age[l] = 0;
                    lit_c[l]   = lit_cnt_s[l];
                    lit_g[l]   = lit_ge_s[l];
                    lit_l[l]   = lit_lat_s[l];
                end
            end
        end
    end

    task automatic tick(input int l);
        @(posedge clk);
        #1;
        if (rand_bp) out_ready_s[l] = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int l, input int n);
        repeat (n) tick(l);
    endtask

    task automatic present(input int l, input logic [31:0] d, input bit z, input int thr,
                           input bit lit, input int lc, input bit lg, input int ll);
        in_data_s[l]  = d;
        in_zeros_s[l] = z;
        thr_s[l]      = CW'(thr);
        lit_on_s[l]   = lit;
        lit_cnt_s[l]  = lc;
        lit_ge_s[l]   = lg;
        lit_lat_s[l]  = ll;
        in_valid_s[l] = 1'b1;
    endtask

    task automatic wait_accept(input int l);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready_s[l]) break;
            tick(l);
            n++;
            if (n > 400) begin
                tmo_cnt++;
                break;
            end
        end
        tick(l);
        in_valid_s[l] = 1'b0;
        lit_on_s[l]   = 1'b0;
    endtask

    task automatic put(input int l, input logic [31:0] d, input bit z, input int thr,
                       input bit lit, input int lc, input bit lg, input int ll);
        present(l, d, z, thr, lit, lc, lg, ll);
        wait_accept(l);
    endtask

    initial begin
        logic [31:0] d;
        for (int l = 0; l < NL; l++) begin
            rst_s[l]       = 1'b1;
            in_valid_s[l]  = 1'b1;
            in_data_s[l]   = $urandom;
            in_zeros_s[l]  = MODE_ONES;
            thr_s[l]       = '0;
            out_ready_s[l] = 1'b1;
            lit_on_s[l]    = 1'b0;
            lit_cnt_s[l]   = 0;
            lit_ge_s[l]    = 1'b0;
            lit_lat_s[l]   = 0;
        end
        @(posedge clk);
        #1;
        chk_on = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int l = 0; l < NL; l++) begin
            rst_s[l]      = 1'b0;
            in_valid_s[l] = 1'b0;
        end
        idle(0, 2);

        put(0, 32'hFFFF_FFFF, 0, 32, 1, 32, 1, 4);
        idle(0, 6);
        put(0, 32'hFFFF_FFFF, 0, 33, 1, 32, 0, 4);
        idle(0, 6);
        put(0, 32'h8000_0001, 1, 31, 1, 30, 0, 4);
        idle(0, 6);

        out_ready_s[0] = 1'b0;
        put(0, 32'hA5A5_0F0F, 0, 16, 1, 16, 1, 4);
        present(0, 32'h8000_0001, 1, 30, 1, 30, 1, 4);
        idle(0, 10);
        out_ready_s[0] = 1'b1;
        wait_accept(0);
        idle(0, 6);

        for (int l = 0; l < NL; l++) begin
            int lat;
            lat = WIDTH / chunk_of(l);
            put(l, 32'h0000_000F, 0, 4, 1, 4, 1, lat);
            put(l, 32'h0000_00FF, 0, 9, 1, 8, 0, lat);
            put(l, 32'h0000_0000, 0, 0, 1, 0, 1, lat);
            idle(l, 8);
        end

        put(0, 32'h1234_5678, 0, 5, 0, 0, 0, 0);
        idle(0, 2);
        rst_s[0] = 1'b1;
        idle(0, 1);
        rst_s[0] = 1'b0;
        put(0, 32'h0000_0003, 0, 2, 1, 2, 1, 4);
        idle(0, 6);

        rand_bp = 1;
        for (int l = 0; l < NL; l++) begin
            for (int k = 0; k < 150; k++) begin
                case ($urandom_range(0, 4))
                    0: d = $urandom;
                    1: d = 32'h0;
                    2: d = 32'hFFFF_FFFF;
                    3: d = 32'h1 << $urandom_range(0, 31);
                    default: d = ~(32'h1 << $urandom_range(0, 31));
                endcase
                put(l, d, 1'($urandom_range(0, 1)), $urandom_range(0, 63), 0, 0, 0, 0);
                idle(l, $urandom_range(0, 3));
            end
        end
        rand_bp = 0;
        for (int l = 0; l < NL; l++) out_ready_s[l] = 1'b1;
        idle(0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
